// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing a shared-memory multicycle MIPS datapath.
// A single memory port and ALU are time-shared, so each instruction takes 3-5 cycles.
// The outputs are Moore-style and decoded from the state register. While reset is high,
// the decode is forced to FETCH and every write enable is held low.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       isjal,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       signext,
  output logic       shiftl16,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTEXEC  = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_IMMEXEC = 4'd9;
  localparam logic [3:0] S_IMMWB   = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_JAL     = 4'd12;
  localparam logic [3:0] S_JR      = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] F_JR     = 6'b001000;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;

  // R-type funct codes that execute through RTEXEC (JR is handled separately)
  function automatic logic rtype_ok(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b101010, 6'b101011: rtype_ok = 1'b1;
      default:                                    rtype_ok = 1'b0;
    endcase
  endfunction

  // ALU operation for an R-type funct field
  function automatic logic [3:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100001: rtype_alu = ALU_ADD;
      6'b100010, 6'b100011: rtype_alu = ALU_SUB;
      6'b100100:            rtype_alu = ALU_AND;
      6'b100101:            rtype_alu = ALU_OR;
      6'b101010:            rtype_alu = ALU_SLT;
      6'b101011:            rtype_alu = ALU_SLTU;
      default:              rtype_alu = ALU_ADD;
    endcase
  endfunction

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] cur_s;
  logic       pcen_s;
  logic       irwrite_s;
  logic       memwrite_s;
  logic       regwrite_s;

  // While reset is high, the outputs decode as FETCH
  assign cur_s = reset ? S_FETCH : state_q;

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode for the current state
  always_comb begin
    state_d    = S_FETCH;
    pcen_s     = 1'b0;
    iord       = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    isjal      = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    signext    = 1'b0;
    shiftl16   = 1'b0;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    case (cur_s)
      S_FETCH: begin
        irwrite_s = 1'b1;
        alusrcb   = 2'b01;
        pcen_s    = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // The ALU computes the branch target speculatively; it is latched in ALUOut
        alusrcb = 2'b11;
        signext = 1'b1;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct == F_JR) begin
              state_d = S_JR;
            end else if (rtype_ok(funct)) begin
              state_d = S_RTEXEC;
            end else begin
              state_d = S_FETCH;
              illegal = 1'b1;
            end
          end
          OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
          OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI:  state_d = S_IMMEXEC;
          OP_J:                               state_d = S_JUMP;
          OP_JAL:                             state_d = S_JAL;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        signext = 1'b1;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_RTEXEC: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu(funct);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_s = 1'b1;
        regdst     = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen_s     = (op == OP_BNE) ? ~zero : zero;
      end
      S_IMMEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_IMMWB;
        case (op)
          OP_ADDI, OP_ADDIU: signext    = 1'b1;
          OP_ORI:            alucontrol = ALU_OR;
          OP_LUI:            shiftl16   = 1'b1;
          default:           alucontrol = ALU_ADD;
        endcase
      end
      S_IMMWB: begin
        regwrite_s = 1'b1;
      end
      S_JUMP: begin
        pcsrc  = 2'b10;
        pcen_s = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4, which is the link value written to r31
        pcsrc      = 2'b10;
        pcen_s     = 1'b1;
        regwrite_s = 1'b1;
        isjal      = 1'b1;
      end
      S_JR: begin
        pcsrc  = 2'b11;
        pcen_s = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // No architectural write may happen in a cycle with reset high
  assign pcen     = pcen_s     & ~reset;
  assign irwrite  = irwrite_s  & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and random instruction streams checked per cycle
// against a behavioural model that classifies instructions and walks their state paths.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       isjal;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       signext;
    logic       shiftl16;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic       illegal;
    logic [3:0] state;
  } ovec_t;

  localparam int C_LW = 0, C_SW = 1, C_RT = 2, C_JR = 3, C_BR = 4,
                 C_IMM = 5, C_J = 6, C_JAL = 7, C_ILL = 8;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] op, funct;
  logic zero;
  logic pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, isjal, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic signext, shiftl16, illegal;
  logic [3:0] alucontrol, state;
  ovec_t got;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .isjal(isjal),
    .alusrca(alusrca), .alusrcb(alusrcb), .signext(signext), .shiftl16(shiftl16),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  assign got = '{pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, isjal,
                 alusrca, alusrcb, signext, shiftl16, pcsrc, alucontrol, illegal, state};

  // Instruction class from the supported-instruction list
  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100, 6'b000101: return C_BR;
      6'b001000, 6'b001001, 6'b001101, 6'b001111: return C_IMM;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      6'b000000: begin
        if (f == 6'b001000) return C_JR;
        if (f inside {6'b100000, 6'b100001, 6'b100010, 6'b100011,
                      6'b100100, 6'b100101, 6'b101010, 6'b101011}) return C_RT;
        return C_ILL;
      end
      default: return C_ILL;
    endcase
  endfunction

  // State path of each class, packed one nibble per cycle, low nibble first
  function automatic logic [19:0] path_of(input int c);
    case (c)
      C_LW:  return 20'h43210;
      C_SW:  return 20'h05210;
      C_RT:  return 20'h07610;
      C_JR:  return 20'h00D10;
      C_BR:  return 20'h00810;
      C_IMM: return 20'h0A910;
      C_J:   return 20'h00B10;
      C_JAL: return 20'h00C10;
      default: return 20'h00010;
    endcase
  endfunction

  function automatic int len_of(input int c);
    case (c)
      C_LW: return 5;
      C_SW, C_RT, C_IMM: return 4;
      C_ILL: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010, 6'b100011: return 4'b1010;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b1011;
      6'b101011: return 4'b1100;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected outputs for a given state, written straight from the per-state output list
  function automatic ovec_t model(input logic [3:0] st, input logic [3:0] shown,
                                  input logic [5:0] o, input logic [5:0] f,
                                  input logic z, input logic rst);
    ovec_t v;
    logic [3:0] s;
    v = '0;
    v.alucontrol = 4'b0010;
    v.state = shown;
    s = rst ? 4'd0 : st;
    case (s)
      4'd0:  begin v.irwrite = 1'b1; v.alusrcb = 2'b01; v.pcen = 1'b1; end
      4'd1:  begin v.alusrcb = 2'b11; v.signext = 1'b1; v.illegal = (classify(o, f) == C_ILL); end
      4'd2:  begin v.alusrca = 1'b1; v.alusrcb = 2'b10; v.signext = 1'b1; end
      4'd3:  v.iord = 1'b1;
      4'd4:  begin v.regwrite = 1'b1; v.memtoreg = 1'b1; end
      4'd5:  begin v.iord = 1'b1; v.memwrite = 1'b1; end
      4'd6:  begin v.alusrca = 1'b1; v.alucontrol = alu_of(f); end
      4'd7:  begin v.regwrite = 1'b1; v.regdst = 1'b1; end
      4'd8:  begin
        v.alusrca = 1'b1; v.alucontrol = 4'b1010; v.pcsrc = 2'b01;
        v.pcen = (o == 6'b000100) ? z : !z;
      end
      4'd9:  begin
        v.alusrca = 1'b1; v.alusrcb = 2'b10;
        v.signext = (o == 6'b001000) || (o == 6'b001001);
        v.shiftl16 = (o == 6'b001111);
        if (o == 6'b001101) v.alucontrol = 4'b0001;
      end
      4'd10: v.regwrite = 1'b1;
      4'd11: begin v.pcsrc = 2'b10; v.pcen = 1'b1; end
      4'd12: begin v.pcsrc = 2'b10; v.pcen = 1'b1; v.regwrite = 1'b1; v.isjal = 1'b1; end
      4'd13: begin v.pcsrc = 2'b11; v.pcen = 1'b1; end
      default: v.state = shown;
    endcase
    if (rst) begin
      v.pcen = 1'b0; v.irwrite = 1'b0; v.memwrite = 1'b0; v.regwrite = 1'b0;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input ovec_t obs, input ovec_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Run one instruction from FETCH; abort_at >= 0 asserts reset at that cycle of the path
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int abort_at);
    int c, n;
    logic [19:0] p;
    logic [3:0] st;
    op = o; funct = f; zero = z;
    c = classify(o, f);
    n = len_of(c);
    p = path_of(c);
    for (int i = 0; i < n; i++) begin
      st = p[4*i +: 4];
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        chk($sformatf("abort op=%b st=%0d", o, st), got, model(st, st, o, f, z, 1'b1));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        return;
      end
      #1;
      chk($sformatf("op=%b f=%b z=%b cyc=%0d", o, f, z, i), got, model(st, st, o, f, z, 1'b0));
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] ops [11] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000,
                           6'b001001, 6'b001101, 6'b001111, 6'b000010, 6'b000011};
  logic [5:0] fns [9]  = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                           6'b100101, 6'b101010, 6'b101011, 6'b001000};

  initial begin
    logic [5:0] ro, rf;
    int ab;
    reset = 1'b1; op = 6'b100011; funct = 6'b000000; zero = 1'b0;
    #1;
    checks++;
    assert ({pcen, irwrite, memwrite, regwrite} === 4'b0000) else begin
      errors++;
      $error("FAIL reset_pre_edge: observed %b expected 0000", {pcen, irwrite, memwrite, regwrite});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("reset_cyc%0d", i), got, model(4'd0, 4'd0, op, funct, zero, 1'b1));
    end
    reset = 1'b0;

    // Directed instruction sequence
    run_instr(6'b100011, 6'b000000, 1'b0, -1);  // LW
    run_instr(6'b101011, 6'b000000, 1'b0, -1);  // SW
    run_instr(6'b000000, 6'b100000, 1'b0, -1);  // ADD
    run_instr(6'b000000, 6'b101011, 1'b0, -1);  // SLTU
    run_instr(6'b000100, 6'b000000, 1'b1, -1);  // BEQ taken
    run_instr(6'b000100, 6'b000000, 1'b0, -1);  // BEQ not taken
    run_instr(6'b000101, 6'b000000, 1'b0, -1);  // BNE taken
    run_instr(6'b000101, 6'b000000, 1'b1, -1);  // BNE not taken
    run_instr(6'b000011, 6'b000000, 1'b0, -1);  // JAL
    run_instr(6'b000000, 6'b001000, 1'b0, -1);  // JR
    run_instr(6'b000010, 6'b000000, 1'b0, -1);  // J
    run_instr(6'b001111, 6'b000000, 1'b0, -1);  // LUI
    run_instr(6'b001101, 6'b000000, 1'b0, -1);  // ORI
    run_instr(6'b001000, 6'b000000, 1'b0, -1);  // ADDI
    run_instr(6'b111111, 6'b000000, 1'b0, -1);  // illegal op
    run_instr(6'b000000, 6'b000111, 1'b0, -1);  // illegal funct
    run_instr(6'b100011, 6'b000000, 1'b0, 3);   // LW, reset in MEMRD
    run_instr(6'b100011, 6'b000000, 1'b0, 4);   // LW, reset in MEMWB
    run_instr(6'b101011, 6'b000000, 1'b0, 3);   // SW, reset in MEMWR
    run_instr(6'b000000, 6'b100010, 1'b0, 3);   // SUB, reset in ALUWB
    run_instr(6'b000011, 6'b000000, 1'b0, 2);   // JAL, reset in JAL
    run_instr(6'b100011, 6'b000000, 1'b0, -1);  // LW after abort

    // Random instruction stream
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) ro = 6'($urandom_range(0, 63));
      else ro = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 7) == 0) rf = 6'($urandom_range(0, 63));
      else rf = fns[$urandom_range(0, 8)];
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(ro, rf, 1'($urandom_range(0, 1)), ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state control unit that sequences a shared-memory, multicycle MIPS datapath: one memory port for instruction and data, one ALU reused for PC increment, branch target and execution. It issues per-cycle enables and mux selects so each instruction runs in 3–5 cycles. The instruction set matches the single-cycle core: R-type ADD/ADDU/SUB/SUBU/AND/OR/SLT/SLTU/JR, LW, SW, BEQ, BNE, ADDI, ADDIU, ORI, LUI, J, JAL.

## Interface
No parameters.
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; state returns to FETCH on the next rising edge
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag, same cycle
- pcen  out  1  PC register load enable
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- irwrite  out  1  instruction register load enable
- memwrite  out  1  memory write strobe
- regwrite  out  1  register file write enable
- regdst  out  1  write address: 0=rt, 1=rd
- memtoreg  out  1  write data: 0=ALUOut, 1=memory data register
- isjal  out  1  force write address 31 and write data PC
- alusrca  out  1  ALU A: 0=PC, 1=A register
- alusrcb  out  2  ALU B: 00=B register, 01=constant 4, 10=extended imm, 11=extended imm<<2
- signext  out  1  1=sign-extend imm, 0=zero-extend
- shiftl16  out  1  extended imm shifted left 16
- pcsrc  out  2  next PC: 00=ALU result, 01=ALUOut, 10={pc[31:28],instr[25:0],2'b00}, 11=A register
- alucontrol  out  4  0010 add, 1010 sub, 0000 and, 0001 or, 1011 slt, 1100 sltu
- illegal  out  1  one-cycle pulse in DECODE for an unsupported op/funct
- state  out  4  current state encoding (debug)

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, ALUWB 7, BRANCH 8, IMMEXEC 9, IMMWB 10, JUMP 11, JAL 12, JR 13. Encodings 14–15 go to FETCH with no writes.
- Default for any output not listed for a state: 0, except alucontrol=0010.
- FETCH: irwrite, alusrcb=01, pcsrc=00, pcen. Next state: DECODE.
- DECODE: alusrcb=11, signext (branch target into ALUOut). Next state by op:
  - 100011 or 101011 → MEMADR
  - 000000 with funct 001000 → JR
  - 000000 with any other supported funct → RTEXEC
  - 000100 or 000101 → BRANCH
  - 001000, 001001, 001101 or 001111 → IMMEXEC
  - 000010 → JUMP; 000011 → JAL
  - anything else → FETCH, with illegal=1
- MEMADR: alusrca, alusrcb=10, signext. Next: MEMRD for LW, MEMWR for SW.
- MEMRD: iord → MEMWB.
- MEMWB: regwrite, memtoreg → FETCH.
- MEMWR: iord, memwrite → FETCH.
- RTEXEC: alusrca, alusrcb=00, alucontrol decoded from funct (100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 101010 slt, 101011 sltu) → ALUWB.
- ALUWB: regwrite, regdst → FETCH.
- BRANCH: alusrca, alusrcb=00, alucontrol=1010, pcsrc=01.
  - pcen = zero for BEQ, ~zero for BNE.
  - Next: FETCH.
- IMMEXEC: alusrca, alusrcb=10, then by op:
  - ADDI/ADDIU: signext, add
  - ORI: zero-extend, or
  - LUI: zero-extend, shiftl16, add
  - Next: IMMWB.
- IMMWB: regwrite, regdst=0, memtoreg=0 → FETCH.
- JUMP: pcsrc=10, pcen → FETCH.
- JAL: pcsrc=10, pcen, regwrite, isjal → FETCH. PC already holds PC+4 at this point.
- JR: pcsrc=11, pcen → FETCH.

## Timing
- Moore outputs, decoded combinationally from the state register. Exceptions: alucontrol also uses funct; DECODE/IMMEXEC selects also use op; pcen in BRANCH also uses zero.
- While reset=1: pcen, irwrite, memwrite and regwrite are forced to 0 in the same cycle; the other outputs show their FETCH values.
- First edge with reset=1: state becomes 0. The first edge after reset deasserts completes FETCH.
- Reset asserted mid-instruction: the instruction is abandoned. No write occurs in any cycle where reset=1.
- Cycles per instruction:
  - LW 5
  - SW, R-type, ADDI/ADDIU/ORI/LUI 4
  - BEQ, BNE, J, JAL, JR 3
  - illegal op/funct 2 (FETCH, DECODE)
- Exactly one pcen pulse per FETCH. At most one further pcen per instruction (branch taken, J, JAL, JR).
- op and funct must stay stable from DECODE through the last state of the instruction.

## Test plan
- Reset held 3 cycles, then released: state=0 and all write enables 0 throughout reset; state sequence 0→1 afterwards; irwrite=1 and pcen=1 in the first FETCH.
- LW (op 100011): states 0,1,2,3,4,0. iord=1 only in MEMRD. regwrite=1, memtoreg=1 only in MEMWB. Total 5 cycles.
- SW then ADD (funct 100000) then SLTU (funct 101011):
  - SW gives memwrite=1 only in state 5.
  - ALU ops give alucontrol 0010 and then 1100 in RTEXEC.
  - regdst=1 in ALUWB.
- BEQ with zero=1, BEQ with zero=0, BNE with zero=0: pcen in BRANCH is 1, 0, 1 respectively; pcsrc=01; 3 cycles each.
- JAL then JR (funct 001000):
  - JAL: state 12 with pcsrc=10, pcen=1, regwrite=1, isjal=1.
  - JR: state 13 with pcsrc=11, pcen=1, regwrite=0.
- Illegal op 111111, then reset asserted during MEMRD of a LW:
  - illegal=1 for exactly one cycle, then state 0 with no writes.
  - Reset cycle: regwrite=0; state=0 on the next edge.
